stack_file_mt: RTL and testbench

STACK_FILE_MT -- requirements
Module: stack_file_mt

---
 rtl/stack_file_mt.sv | 192 +++++++++++++++++++
 tb/tb_stack_file_mt.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_file_mt.sv
// Multi-thread stack register file: one LIFO per hardware thread, single request port,
// one-cycle registered response carrying post-op top two entries; held while rsp_ready is low.
module stack_file_mt #(
  parameter  int THREADS = 2,
  parameter  int DEPTH   = 256,
  parameter  int WIDTH   = 16,
  localparam int TW      = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int AW      = CW - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TW-1:0]      req_tid,
  input  logic [2:0]         req_op,
  input  logic [11:0]        req_imm,
  input  logic [WIDTH-1:0]   req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TW-1:0]      rsp_tid,
  output logic [WIDTH-1:0]   rsp_top,
  output logic [WIDTH-1:0]   rsp_next,
  output logic               rsp_err,
  output logic [THREADS-1:0] err_ovf,
  output logic [THREADS-1:0] err_unf
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_DUP   = 3'b011;
  localparam logic [2:0] OP_GET   = 3'b100;
  localparam logic [2:0] OP_PEEK  = 3'b101;
  localparam logic [2:0] OP_REPL2 = 3'b110;
  localparam logic [2:0] OP_CLR   = 3'b111;

  logic [WIDTH-1:0]   mem_q [THREADS][DEPTH];
  logic [CW-1:0]      cnt_q [THREADS];
  logic               arm_q;
  logic               rsp_valid_q;
  logic [TW-1:0]      rsp_tid_q;
  logic [WIDTH-1:0]   rsp_top_q, rsp_next_q;
  logic               rsp_err_q;
  logic [THREADS-1:0] err_ovf_q, err_ovf_d;
  logic [THREADS-1:0] err_unf_q, err_unf_d;

  logic               accept;
  logic [CW-1:0]      cnt_cur, ncnt;
  logic [11:0]        c12;
  logic               full;
  logic [WIDTH-1:0]   top_rd, get_rd;
  logic               we;
  logic [AW-1:0]      widx;
  logic [WIDTH-1:0]   wdat;
  logic               ovf, unf, clr;
  logic [AW-1:0]      i0, i1;
  logic [WIDTH-1:0]   s0, s1;

  // arm_q keeps a request that lands on the reset-release edge from being taken.
  assign req_ready = !(rsp_valid_q && !rsp_ready);
  assign accept    = req_valid && req_ready && arm_q;

  always_comb begin
    cnt_cur = cnt_q[req_tid];
    c12     = 12'(cnt_cur);
    full    = (cnt_cur == CW'(DEPTH));
    top_rd  = mem_q[req_tid][AW'(cnt_cur - CW'(1))];
    get_rd  = mem_q[req_tid][AW'(c12 - 12'd1 - req_imm)];
    ncnt    = cnt_cur;
    we      = 1'b0;
    widx    = AW'(cnt_cur);
    wdat    = req_data;
    ovf     = 1'b0;
    unf     = 1'b0;
    clr     = 1'b0;
    case (req_op)
      OP_PUSH: begin
        if (full) ovf = 1'b1;
        else begin
          we   = 1'b1;
          ncnt = cnt_cur + CW'(1);
        end
      end
      OP_POP: begin
        if (req_imm > c12) begin
          unf  = 1'b1;
          ncnt = '0;
        end else begin
          ncnt = CW'(c12 - req_imm);
        end
      end
      OP_DUP: begin
        if (cnt_cur == '0) unf = 1'b1;
        else if (full) ovf = 1'b1;
        else begin
          we   = 1'b1;
          wdat = top_rd;
          ncnt = cnt_cur + CW'(1);
        end
      end
      OP_GET: begin
        if (full) ovf = 1'b1;
        else if (req_imm >= c12) unf = 1'b1;
        else begin
          we   = 1'b1;
          wdat = get_rd;
          ncnt = cnt_cur + CW'(1);
        end
      end
      OP_PEEK: begin
        if (cnt_cur < CW'(2)) unf = 1'b1;
      end
      OP_REPL2: begin
        if (cnt_cur < CW'(2)) unf = 1'b1;
        else begin
          we   = 1'b1;
          widx = AW'(cnt_cur - CW'(2));
          ncnt = cnt_cur - CW'(1);
        end
      end
      OP_CLR: begin
        clr  = 1'b1;
        ncnt = '0;
      end
      default: ;
    endcase
  end

  // Post-op s0/s1 see the word being written this cycle, so the response and
  // the next request both observe the updated stack without a bubble.
  always_comb begin
    i0 = AW'(ncnt - CW'(1));
    i1 = AW'(ncnt - CW'(2));
    s0 = '0;
    s1 = '0;
    if (ncnt >= CW'(1)) s0 = (we && widx == i0) ? wdat : mem_q[req_tid][i0];
    if (ncnt >= CW'(2)) s1 = (we && widx == i1) ? wdat : mem_q[req_tid][i1];
  end

  always_comb begin
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    if (clr) begin
      err_ovf_d[req_tid] = 1'b0;
      err_unf_d[req_tid] = 1'b0;
    end
    if (ovf) err_ovf_d[req_tid] = 1'b1;
    if (unf) err_unf_d[req_tid] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_top_q   <= '0;
      rsp_next_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_ovf_q   <= '0;
      err_unf_q   <= '0;
      for (int t = 0; t < THREADS; t++) cnt_q[t] <= '0;
    end else begin
      arm_q <= 1'b1;
      if (accept) begin
        cnt_q[req_tid] <= ncnt;
        rsp_valid_q    <= 1'b1;
        rsp_tid_q      <= req_tid;
        rsp_top_q      <= s0;
        rsp_next_q     <= s1;
        rsp_err_q      <= ovf || unf;
        err_ovf_q      <= err_ovf_d;
        err_unf_q      <= err_unf_d;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && we) mem_q[req_tid][widx] <= wdat;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_top   = rsp_top_q;
  assign rsp_next  = rsp_next_q;
  assign rsp_err   = rsp_err_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_stack_file_mt.sv
// Directed bench for stack_file_mt (2 threads, depth 4): scoreboard queue plus
// a monitor that checks every response handshake.
module tb_stack_file_mt;

  localparam int THREADS = 2;
  localparam int DEPTH   = 4;
  localparam int WIDTH   = 16;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] GET = 3'd4, PEEK = 3'd5, REPL2 = 3'd6, CLR = 3'd7;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [0:0]         req_tid = '0;
  logic [2:0]         req_op = '0;
  logic [11:0]        req_imm = '0;
  logic [WIDTH-1:0]   req_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [0:0]         rsp_tid;
  logic [WIDTH-1:0]   rsp_top, rsp_next;
  logic               rsp_err;
  logic [THREADS-1:0] err_ovf, err_unf;

  typedef struct {
    logic [0:0]       tid;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nxt;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  stack_file_mt #(.THREADS(THREADS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid),
    .req_op(req_op), .req_imm(req_imm), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tid(rsp_tid),
    .rsp_top(rsp_top), .rsp_next(rsp_next), .rsp_err(rsp_err),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one response per negedge where the handshake is about to complete.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got tid=%h top=%h next=%h err=%b expected none",
                 rsp_tid, rsp_top, rsp_next, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (rsp_tid !== e.tid || rsp_top !== e.top || rsp_next !== e.nxt || rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp: got tid=%h top=%h next=%h err=%b expected tid=%h top=%h next=%h err=%b",
                   rsp_tid, rsp_top, rsp_next, rsp_err, e.tid, e.top, e.nxt, e.err);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [0:0] tid, input logic [2:0] op, input logic [11:0] imm,
                       input logic [15:0] data, input logic [15:0] et, input logic [15:0] en,
                       input logic ee, output int cycles);
    exp_t e;
    logic rdy;
    e.tid = tid; e.top = et; e.nxt = en; e.err = ee;
    exp_q.push_back(e);
    req_valid = 1'b1; req_tid = tid; req_op = op; req_imm = imm; req_data = data;
    cycles = 0;
    do begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      cycles++;
    end while (!rdy && cycles < 20);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no req_ready expected req_ready within 20 cycles");
    end
    req_valid = 1'b0;
  endtask

  task automatic req(input logic [0:0] tid, input logic [2:0] op, input logic [11:0] imm,
                     input logic [15:0] data, input logic [15:0] et, input logic [15:0] en,
                     input logic ee);
    int n;
    issue(tid, op, imm, data, et, en, ee, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_top", 32'(rsp_top), 32'd0);
    chk("reset_flags", {err_ovf, err_unf}, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    req(0, PUSH, 0, 16'h1111, 16'h1111, 16'h0000, 0);
    req(0, PUSH, 0, 16'h2222, 16'h2222, 16'h1111, 0);
    req(0, PEEK, 0, 0, 16'h2222, 16'h1111, 0);
    req(1, POP, 3, 0, 16'h0000, 16'h0000, 1);
    @(negedge clk);
    chk("t1_unf_flag", 32'(err_unf), 32'b10);
    @(posedge clk);
    #1;
    req(0, PEEK, 0, 0, 16'h2222, 16'h1111, 0);
    req(0, PUSH, 0, 16'h3333, 16'h3333, 16'h2222, 0);
    req(0, PUSH, 0, 16'h4444, 16'h4444, 16'h3333, 0);
    req(0, PUSH, 0, 16'h5555, 16'h4444, 16'h3333, 1);
    @(negedge clk);
    chk("t0_ovf_flag", 32'(err_ovf), 32'b01);
    @(posedge clk);
    #1;
    req(0, PEEK, 0, 0, 16'h4444, 16'h3333, 0);
    req(0, CLR, 0, 0, 16'h0000, 16'h0000, 0);
    @(negedge clk);
    chk("clr_flags", {err_ovf, err_unf}, 32'b0010);
    @(posedge clk);
    #1;
    req(0, PEEK, 0, 0, 16'h0000, 16'h0000, 1);
    req(0, CLR, 0, 0, 16'h0000, 16'h0000, 0);
    req(1, CLR, 0, 0, 16'h0000, 16'h0000, 0);

    req(0, PUSH, 0, 16'd5, 16'd5, 16'd0, 0);
    req(0, PUSH, 0, 16'd7, 16'd7, 16'd5, 0);
    req(0, PUSH, 0, 16'd9, 16'd9, 16'd7, 0);
    req(0, GET, 2, 0, 16'd5, 16'd9, 0);
    req(0, REPL2, 0, 16'h0010, 16'h0010, 16'd7, 0);
    req(0, POP, 0, 0, 16'h0010, 16'd7, 0);
    req(0, POP, 3, 0, 16'h0000, 16'h0000, 0);
    req(0, DUP, 0, 0, 16'h0000, 16'h0000, 1);
    req(0, CLR, 0, 0, 16'h0000, 16'h0000, 0);

    req(1, PUSH, 0, 16'haaaa, 16'haaaa, 16'h0000, 0);
    req(0, PUSH, 0, 16'hbbbb, 16'hbbbb, 16'h0000, 0);
    req(1, DUP, 0, 0, 16'haaaa, 16'haaaa, 0);
    req(0, GET, 0, 0, 16'hbbbb, 16'hbbbb, 0);
    req(1, NOP, 0, 0, 16'haaaa, 16'haaaa, 0);
    req(0, GET, 5, 0, 16'hbbbb, 16'hbbbb, 1);
    @(negedge clk);
    chk("get_unf_flags", {err_ovf, err_unf}, 32'b0001);
    @(posedge clk);
    #1;

    // Backpressure: response must hold for three stalled cycles.
    rsp_ready = 1'b0;
    req(0, PUSH, 0, 16'hcccc, 16'hcccc, 16'hbbbb, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_hold", {15'd0, rsp_valid, rsp_top}, {15'd0, 1'b1, 16'hcccc});
      chk("stall_next_hold", 32'(rsp_next), 32'hbbbb);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    issue(0, PEEK, 0, 0, 16'hcccc, 16'hbbbb, 0, n);
    chk("release_accept_cycles", n, 32'd1);
    @(posedge clk);
    #1;

    // Reset during a stall drops the pending response.
    rsp_ready = 1'b0;
    req(1, PUSH, 0, 16'hdddd, 16'hdddd, 16'haaaa, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midstall_rst_valid", 32'(rsp_valid), 32'd0);
    chk("midstall_rst_flags", {err_ovf, err_unf}, 32'd0);
    chk("midstall_rst_top", 32'(rsp_top), 32'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_tid = 0; req_op = PUSH; req_data = 16'heeee;
    @(negedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    req_valid = 1'b0;
    req(0, PEEK, 0, 0, 16'h0000, 16'h0000, 1);
    req(1, PEEK, 0, 0, 16'h0000, 16'h0000, 1);
    @(negedge clk);
    chk("post_rst_unf", 32'(err_unf), 32'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
